// File: rtl/emesh_reg_master_pkg.sv
// Shared op codes, status codes, FSM states and fixed packet field values
// for the emesh register-access initiator.
package emesh_reg_master_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_POLL  = 2'd2,
    OP_RSVD  = 2'd3
  } rm_op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_BADOP   = 2'd2
  } rm_status_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_RESP  = 3'd4
  } rm_state_e;

  localparam logic [1:0] DATAMODE_WORD = 2'b10;
  localparam logic [4:0] CTRLMODE_NONE = 5'd0;
  localparam int unsigned ATT_W        = 16;

endpackage

// File: rtl/emesh_reg_master_e2p.sv
// Packs single-beat register access fields into an emesh packet:
// {srcaddr, data, dstaddr, ctrlmode, datamode, write}.
module emesh_reg_master_e2p
  import emesh_reg_master_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned PW      = 2*AW+40,
  parameter int unsigned ID      = 0,
  parameter int unsigned SRCADDR = 0
) (
  input  logic          i_write,
  input  logic [5:0]    i_reg,
  input  logic [AW-1:0] i_data,
  output logic [PW-1:0] o_packet_c
);

  localparam int unsigned SW = PW - 8 - 2*AW;
  localparam logic [2:0]  ID3 = 3'(ID);

  logic [AW-1:0] w_dstaddr;

  assign w_dstaddr  = AW'({ID3, i_reg, 2'b00});
  assign o_packet_c = {SW'(SRCADDR), i_data, w_dstaddr, CTRLMODE_NONE, DATAMODE_WORD, i_write};

endmodule

// File: rtl/emesh_reg_master.sv
// Register-access initiator: turns host WRITE/READ/POLL commands into single-beat
// emesh packets and returns read data, status and attempt count.
module emesh_reg_master
  import emesh_reg_master_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned PW       = 2*AW+40,
  parameter int unsigned ID       = 0,
  parameter int unsigned SRCADDR  = 0,
  parameter int unsigned POLL_MAX = 256,
  parameter int unsigned POLL_GAP = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [5:0]       cmd_reg,
  input  logic [AW-1:0]    cmd_data,
  input  logic [AW-1:0]    cmd_mask,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic [AW-1:0]    rsp_data,
  output logic [ATT_W-1:0] rsp_attempts,
  output logic             reg_access,
  output logic [PW-1:0]    reg_packet,
  input  logic [AW-1:0]    reg_rdata,
  output logic             busy
);

  localparam int unsigned POLL_LIM = (POLL_MAX == 0) ? 1 : ((POLL_MAX > 65535) ? 65535 : POLL_MAX);
  localparam int unsigned GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  rm_state_e        r_state, w_state_nxt;
  rm_op_e           r_op, w_op_nxt;
  logic [5:0]       r_reg, w_reg_nxt;
  logic [AW-1:0]    r_data, w_data_nxt;
  logic [AW-1:0]    r_mask, w_mask_nxt;
  rm_status_e       r_rsp_status, w_status_nxt;
  logic [AW-1:0]    r_rsp_data, w_rdata_nxt;
  logic [ATT_W-1:0] r_attempts, w_attempts_nxt;
  logic [GW-1:0]    r_gap, w_gap_nxt;
  logic             r_cmd_ready, w_cmd_ready_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic             r_busy, r_access;
  logic [PW-1:0]    r_packet;
  logic             w_accept, w_match, w_issue;
  logic [AW-1:0]    w_pk_data;
  logic [PW-1:0]    w_packet;

  // Next-state and next-value logic; outputs below are all registered.
  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_reg_nxt       = r_reg;
    w_data_nxt      = r_data;
    w_mask_nxt      = r_mask;
    w_status_nxt    = r_rsp_status;
    w_rdata_nxt     = r_rsp_data;
    w_attempts_nxt  = r_attempts;
    w_gap_nxt       = r_gap;
    w_cmd_ready_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_accept        = r_cmd_ready & cmd_valid;
    w_match         = ((reg_rdata ^ r_data) & r_mask) == '0;
    unique case (r_state)
      S_IDLE: begin
        w_cmd_ready_nxt = ~w_accept;
        if (w_accept) begin
          w_op_nxt       = rm_op_e'(cmd_op);
          w_reg_nxt      = cmd_reg;
          w_data_nxt     = cmd_data;
          w_mask_nxt     = cmd_mask;
          w_rdata_nxt    = '0;
          w_attempts_nxt = '0;
          w_status_nxt   = ST_OK;
          if (rm_op_e'(cmd_op) == OP_RSVD) begin
            w_state_nxt  = S_RESP;
            w_status_nxt = ST_BADOP;
          end else begin
            w_state_nxt  = S_ISSUE;
          end
        end
      end
      S_ISSUE: w_state_nxt = (r_op == OP_WRITE) ? S_RESP : S_WAIT;
      S_WAIT: begin
        w_rdata_nxt = reg_rdata;
        if (r_op == OP_READ || w_match) begin
          w_state_nxt  = S_RESP;
          w_status_nxt = ST_OK;
        end else if (r_attempts >= ATT_W'(POLL_LIM)) begin
          w_state_nxt  = S_RESP;
          w_status_nxt = ST_TIMEOUT;
        end else if (POLL_GAP == 0) begin
          w_state_nxt  = S_ISSUE;
        end else begin
          w_state_nxt  = S_GAP;
          w_gap_nxt    = GW'(POLL_GAP - 1);
        end
      end
      S_GAP: begin
        if (r_gap == '0) w_state_nxt = S_ISSUE;
        else             w_gap_nxt   = r_gap - GW'(1);
      end
      S_RESP: begin
        if (r_rsp_valid && rsp_ready) w_state_nxt = S_IDLE;
        else                          w_rsp_valid_nxt = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_issue = (w_state_nxt == S_ISSUE);
    // Count a read each time one is launched, saturating.
    if (w_issue && w_op_nxt != OP_WRITE && w_attempts_nxt != '1)
      w_attempts_nxt = w_attempts_nxt + ATT_W'(1);
  end

  assign w_pk_data = (w_op_nxt == OP_WRITE) ? w_data_nxt : '0;

  emesh_reg_master_e2p #(
    .AW      (AW),
    .PW      (PW),
    .ID      (ID),
    .SRCADDR (SRCADDR)
  ) u_e2p (
    .i_write    (w_op_nxt == OP_WRITE),
    .i_reg      (w_reg_nxt),
    .i_data     (w_pk_data),
    .o_packet_c (w_packet)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state      <= S_IDLE;
      r_op         <= OP_WRITE;
      r_reg        <= '0;
      r_data       <= '0;
      r_mask       <= '0;
      r_rsp_status <= ST_OK;
      r_rsp_data   <= '0;
      r_attempts   <= '0;
      r_gap        <= '0;
      r_cmd_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_access     <= 1'b0;
      r_packet     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_reg        <= w_reg_nxt;
      r_data       <= w_data_nxt;
      r_mask       <= w_mask_nxt;
      r_rsp_status <= w_status_nxt;
      r_rsp_data   <= w_rdata_nxt;
      r_attempts   <= w_attempts_nxt;
      r_gap        <= w_gap_nxt;
      r_cmd_ready  <= w_cmd_ready_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_access     <= w_issue;
      if (w_issue) r_packet <= w_packet;
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_status   = r_rsp_status;
  assign rsp_data     = r_rsp_data;
  assign rsp_attempts = r_attempts;
  assign reg_access   = r_access;
  assign reg_packet   = r_packet;
  assign busy         = r_busy;

endmodule

// File: tb/tb_emesh_reg_master.sv
// Directed bench for emesh_reg_master against a small GPIO-like register slave.
module tb_emesh_reg_master;

  localparam int unsigned AW = 32;
  localparam int unsigned PW = 2*AW+40;
  localparam logic [5:0]  GPIO_OEN   = 6'd1;
  localparam logic [5:0]  GPIO_IDATA = 6'd4;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [5:0]    cmd_reg = 6'd0;
  logic [31:0]   cmd_data = 32'd0;
  logic [31:0]   cmd_mask = 32'd0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_status;
  logic [31:0]   rsp_data;
  logic [15:0]   rsp_attempts;
  logic          reg_access;
  logic [PW-1:0] reg_packet;
  logic [31:0]   reg_rdata = 32'd0;
  logic          busy;

  logic [23:0]   gpio_in = 24'd0;
  logic [23:0]   regs [64] = '{default: 24'h0};
  int            cyc = 0;
  int            pulse_q[$];
  logic [PW-1:0] last_pkt = '0;
  int            valid_cycles = 0;
  int            n_checks = 0;
  int            n_errors = 0;

  emesh_reg_master #(
    .AW(AW), .PW(PW), .ID(0), .SRCADDR(32'h0000_0ABC), .POLL_MAX(5), .POLL_GAP(4)
  ) dut (
    .clk(clk), .nreset(nreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_reg(cmd_reg),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_data(rsp_data), .rsp_attempts(rsp_attempts),
    .reg_access(reg_access), .reg_packet(reg_packet), .reg_rdata(reg_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // GPIO-like slave: OEN is read/write, IDATA reflects gpio_in; data valid the cycle after the access.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reg_access) begin
      if (reg_packet[0]) regs[reg_packet[15:10]] <= reg_packet[63:40];
      else if (reg_packet[15:10] == GPIO_IDATA) reg_rdata <= {8'h0, gpio_in};
      else reg_rdata <= {8'h0, regs[reg_packet[15:10]]};
    end
  end

  always @(negedge clk) begin
    if (reg_access) begin
      pulse_q.push_back(cyc);
      last_pkt = reg_packet;
    end
    if (rsp_valid) valid_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] rg, input logic [31:0] d,
                      input logic [31:0] m);
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin
      tick();
      w++;
    end
    chk("cmd_ready_before_send", 128'(cmd_ready), 128'(1));
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_reg   = rg;
    cmd_data  = d;
    cmd_mask  = m;
    pulse_q.delete();
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int c);
    c = 0;
    while (!rsp_valid && c < 100) begin
      tick();
      c++;
    end
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_ack", 128'(rsp_valid), 128'(0));
  endtask

  initial begin
    int lat;
    int np;
    int nv;
    // Reset state
    repeat (3) tick();
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_reg_access", 128'(reg_access), 128'(0));
    chk("rst_reg_packet", 128'(reg_packet), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_fields", 128'({rsp_status, rsp_data, rsp_attempts}), 128'(0));
    nreset = 1'b1;
    tick();
    chk("cmd_ready_after_rst", 128'(cmd_ready), 128'(1));

    // WRITE OEN = 0x00FF00
    send(2'd0, GPIO_OEN, 32'h0000_FF00, 32'h0);
    chk("wr_busy", 128'(busy), 128'(1));
    chk("wr_cmd_ready_low", 128'(cmd_ready), 128'(0));
    wait_rsp(lat);
    chk("wr_latency", 128'(lat), 128'(2));
    chk("wr_pulses", 128'(pulse_q.size()), 128'(1));
    chk("wr_packet", 128'(last_pkt), 128'(104'h00000ABC_0000FF00_00000004_05));
    chk("wr_status", 128'(rsp_status), 128'(0));
    chk("wr_data", 128'(rsp_data), 128'(0));
    chk("wr_attempts", 128'(rsp_attempts), 128'(0));
    ack_rsp();
    chk("cmd_ready_low_after_ack", 128'(cmd_ready), 128'(0));
    tick();
    chk("cmd_ready_rises", 128'(cmd_ready), 128'(1));

    // READ OEN
    send(2'd1, GPIO_OEN, 32'hDEAD_BEEF, 32'h0);
    wait_rsp(lat);
    chk("rd_oen_latency", 128'(lat), 128'(3));
    chk("rd_oen_packet", 128'(last_pkt), 128'(104'h00000ABC_00000000_00000004_04));
    chk("rd_oen_data", 128'(rsp_data), 128'(32'h0000_FF00));
    chk("rd_oen_status", 128'(rsp_status), 128'(0));
    chk("rd_oen_attempts", 128'(rsp_attempts), 128'(1));
    ack_rsp();

    // READ IDATA with inputs held
    gpio_in = 24'hA5A5A5;
    send(2'd1, GPIO_IDATA, 32'h0, 32'h0);
    wait_rsp(lat);
    chk("rd_idata_latency", 128'(lat), 128'(3));
    chk("rd_idata_data", 128'(rsp_data), 128'(32'h00A5_A5A5));
    chk("rd_idata_pulses", 128'(pulse_q.size()), 128'(1));
    ack_rsp();

    // POLL IDATA bit0 == 1; bit0 rises 10 cycles in, caught by the third read
    gpio_in = 24'hA5A5A4;
    send(2'd2, GPIO_IDATA, 32'h1, 32'h1);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      tick();
      lat++;
      if (lat == 2) chk("poll_cmd_ready_busy", 128'({cmd_ready, busy}), 128'(2'b01));
      if (lat == 10) gpio_in = 24'hA5A5A5;
    end
    chk("poll_latency", 128'(lat), 128'(15));
    chk("poll_status", 128'(rsp_status), 128'(0));
    chk("poll_attempts", 128'(rsp_attempts), 128'(3));
    chk("poll_pulses", 128'(pulse_q.size()), 128'(3));
    chk("poll_gap_1", 128'(pulse_q[1] - pulse_q[0]), 128'(6));
    chk("poll_gap_2", 128'(pulse_q[2] - pulse_q[1]), 128'(6));
    chk("poll_data", 128'(rsp_data), 128'(32'h00A5_A5A5));
    ack_rsp();

    // POLL that never matches -> TIMEOUT after POLL_MAX reads
    send(2'd2, GPIO_IDATA, 32'h0, 32'h1);
    wait_rsp(lat);
    chk("to_latency", 128'(lat), 128'(27));
    chk("to_pulses", 128'(pulse_q.size()), 128'(5));
    chk("to_status", 128'(rsp_status), 128'(1));
    chk("to_attempts", 128'(rsp_attempts), 128'(5));
    chk("to_data", 128'(rsp_data), 128'(32'h00A5_A5A5));
    ack_rsp();

    // Reserved op -> BADOP, response held under back-pressure
    send(2'd3, GPIO_OEN, 32'h1234_5678, 32'h0);
    wait_rsp(lat);
    chk("bad_latency", 128'(lat), 128'(1));
    for (int i = 0; i < 7; i++) begin
      chk("bad_hold", 128'({rsp_valid, cmd_ready, rsp_status, rsp_data, rsp_attempts}),
          128'({1'b1, 1'b0, 2'd2, 32'h0, 16'h0}));
      tick();
    end
    chk("bad_pulses", 128'(pulse_q.size()), 128'(0));
    ack_rsp();

    // Reset during a POLL gap aborts the command silently
    send(2'd2, GPIO_IDATA, 32'h0, 32'h1);
    repeat (3) tick();
    chk("abort_in_gap", 128'({busy, reg_access}), 128'(2'b10));
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_access", 128'(reg_access), 128'(0));
    chk("abort_rsp_valid", 128'(rsp_valid), 128'(0));
    np = pulse_q.size();
    nv = valid_cycles;
    repeat (20) tick();
    chk("abort_no_more_pulses", 128'(pulse_q.size()), 128'(np));
    chk("abort_no_rsp", 128'(valid_cycles), 128'(nv));
    chk("abort_cmd_ready", 128'(cmd_ready), 128'(1));
    send(2'd1, GPIO_OEN, 32'h0, 32'h0);
    wait_rsp(lat);
    chk("post_abort_latency", 128'(lat), 128'(3));
    chk("post_abort_data", 128'(rsp_data), 128'(32'h0000_FF00));
    chk("post_abort_attempts", 128'(rsp_attempts), 128'(1));
    ack_rsp();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
